// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: CPU-fed byte FIFO, programmable bit divisor,
// and a level IRQ that asks for a refill once the line has fully drained.
module uart_tx_dev #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]    reg_sel;
    logic          wr_ctrl, wr_div, wr_status, push, push_ok, pop;
    logic          txen_reg, ie_reg, overflow_reg;
    logic [15:0]   divisor_reg;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [3:0]    count_view;
    logic          fifo_full, fifo_empty;
    state_t        state_reg, state_next;
    logic [15:0]   baud_cnt_reg, baud_cnt_next, eff_div_reg, eff_div_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_view;
    logic          shift_en, bit_done, tx_reg, tx_next, irq_reg;
    logic          unused_bits;

    assign reg_sel    = Addr[3:2];
    assign wr_ctrl    = WE && (reg_sel == 2'd0);
    assign wr_div     = WE && (reg_sel == 2'd1);
    assign push       = WE && (reg_sel == 2'd2);
    assign wr_status  = WE && (reg_sel == 2'd3);
    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    // A push into a full FIFO only lands if the transmitter frees a slot that same cycle
    assign push_ok    = push && (!fifo_full || pop);
    assign unused_bits = ^{Addr[29:4], Addr[1:0], Din[31:16]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_count_view
            if (gi < CW) begin : g_bit
                assign count_view[gi] = count_reg[gi];
            end else begin : g_pad
                assign count_view[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            txen_reg     <= 1'b0;
            ie_reg       <= 1'b0;
            divisor_reg  <= 16'(DEFAULT_DIV);
            overflow_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (wr_ctrl) begin
                txen_reg <= Din[0];
                ie_reg   <= Din[1];
            end
            if (wr_div)
                divisor_reg <= Din[15:0];
            if (wr_status)
                overflow_reg <= 1'b0;
            else if (push && !push_ok)
                overflow_reg <= 1'b1;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (push_ok && !pop)
                count_reg <= count_reg + CW'(1);
            else if (pop && !push_ok)
                count_reg <= count_reg - CW'(1);
        end
    end

    // Storage and head read are both registered so the FIFO maps onto block RAM
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= Din[7:0];
        if (pop)
            shift_reg <= fifo_mem[rd_ptr_reg];
        else if (shift_en)
            shift_reg <= shift_view;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            eff_div_reg  <= 16'd1;
            tx_reg       <= 1'b1;
            irq_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            eff_div_reg  <= eff_div_next;
            tx_reg       <= tx_next;
            irq_reg      <= ie_reg && fifo_empty && (state_reg == IDLE);
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        eff_div_next  = eff_div_reg;
        pop           = 1'b0;
        shift_en      = 1'b0;
        bit_done      = (baud_cnt_reg == eff_div_reg - 16'd1);
        case (state_reg)
            IDLE: begin
                if (txen_reg && !fifo_empty) begin
                    pop           = 1'b1;
                    // Divisor is sampled once per frame so mid-frame rewrites cannot skew it
                    eff_div_next  = (divisor_reg == 16'd0) ? 16'd1 : divisor_reg;
                    baud_cnt_next = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next    = DATA;
                    bit_idx_next  = '0;
                    baud_cnt_next = '0;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_cnt_next = '0;
                    shift_en      = 1'b1;
                    if (bit_idx_reg == 3'd7)
                        state_next = STOP;
                    else
                        bit_idx_next = bit_idx_reg + 3'd1;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next    = IDLE;
                    baud_cnt_next = '0;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        shift_view = shift_en ? {1'b0, shift_reg[7:1]} : shift_reg;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_view[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_comb begin
        Dout = '0;
        case (reg_sel)
            2'd0:    Dout[1:0]  = {ie_reg, txen_reg};
            2'd1:    Dout[15:0] = divisor_reg;
            2'd3:    Dout[7:0]  = {count_view, overflow_reg, fifo_empty, fifo_full,
                                   (state_reg != IDLE)};
            default: Dout = '0;
        endcase
    end

    assign tx  = tx_reg;
    assign IRQ = irq_reg;
endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: a queue-based line-waveform model checks tx/IRQ every
// cycle, and hand-computed literals pin register reads and key frame timing points.
module tb_uart_tx_dev;
    logic        clk, reset, WE, IRQ, tx;
    logic [29:0] Addr;
    logic [31:0] Din, Dout;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    logic tx_s   [128];
    logic busy_s [128];
    logic irq_s  [128];

    // Model state: pending bytes, remaining line levels of the frame in flight
    logic [7:0] m_fifo [$];
    logic [7:0] m_sent [$];
    bit         m_wave [$];
    bit         m_in_frame = 0, m_txen = 0, m_ie = 0, m_ovf = 0;
    logic [15:0] m_div = 16;
    logic       m_tx = 1, m_irq = 0;

    uart_tx_dev #(.FIFO_DEPTH(4), .DEFAULT_DIV(16)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
        .Din(Din), .Dout(Dout), .IRQ(IRQ), .tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] b;
        int         eff;
        bit         lvl;
        if (!reset) begin
            m_fifo.delete();
            m_wave.delete();
            m_in_frame = 0; m_txen = 0; m_ie = 0; m_ovf = 0;
            m_div = 16; m_tx = 1; m_irq = 0;
            return;
        end
        m_irq = m_ie && (m_fifo.size() == 0) && !m_in_frame;
        if (m_in_frame) begin
            if (m_wave.size() > 0) m_tx = m_wave.pop_front();
            else begin m_in_frame = 0; m_tx = 1; end
        end else if (m_txen && m_fifo.size() > 0) begin
            b = m_fifo.pop_front();
            m_sent.push_back(b);
            eff = (m_div == 0) ? 1 : int'(m_div);
            for (int k = 0; k < 10; k++) begin
                lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                repeat (eff) m_wave.push_back(lvl);
            end
            m_tx = m_wave.pop_front();
            m_in_frame = 1;
        end else begin
            m_tx = 1;
        end
        if (WE) begin
            case (Addr[3:2])
                2'd0: begin m_txen = Din[0]; m_ie = Din[1]; end
                2'd1: m_div = Din[15:0];
                2'd2: if (m_fifo.size() < 4) m_fifo.push_back(Din[7:0]); else m_ovf = 1;
                default: m_ovf = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            chk("tx_vs_model", tx, m_tx);
            chk("irq_vs_model", IRQ, m_irq);
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        $display("wr reg=%0d data=0x%08h", a, d);
        Addr = {26'd0, a, 2'b00};
        Din  = d;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
    endtask

    task automatic rd_lit(input logic [1:0] a, input logic [31:0] expv, input string name);
        Addr = {26'd0, a, 2'b00};
        #1;
        $display("rd reg=%0d data=0x%08h", a, Dout);
        chk(name, Dout, expv);
    endtask

    task automatic wait_idle(input int maxc);
        bit ok = 0;
        Addr = {26'd0, 2'd3, 2'b00};
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            #1;
            if (Dout[2:0] == 3'b100) ok = 1;
        end
        chk("wait_idle_bound", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_order [5];
        bit         exp55     [10];
        exp_order = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h16};
        exp55     = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        reset = 1'b0; WE = 1'b0; Addr = '0; Din = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_en = 1;
        rd_lit(2'd3, 32'h0000_0004, "reset_status");
        rd_lit(2'd1, 32'h0000_0010, "reset_divisor");
        chk("reset_tx", tx, 1);
        chk("reset_irq", IRQ, 0);
        reset = 1'b1;

        // Single 0x55 frame at divisor 4
        wr(2'd1, 32'd4);
        wr(2'd0, 32'd1);
        wr(2'd2, 32'h55);
        chk("pre_start_tx", tx, 1);
        Addr = {26'd0, 2'd3, 2'b00};
        for (int j = 0; j <= 40; j++) begin
            @(negedge clk);
            tx_s[j] = tx; busy_s[j] = Dout[0];
        end
        for (int k = 0; k < 10; k++) chk("frame55_level", tx_s[4*k+2], exp55[k]);
        chk("frame55_start_end", tx_s[3], 0);
        chk("frame55_bit0_begin", tx_s[4], 1);
        chk("frame55_busy_last", busy_s[39], 1);
        chk("frame55_busy_drop", busy_s[40], 0);

        // Overflow, overflow clear, push+pop while full, then drain in order
        wr(2'd0, 32'd0);
        for (int k = 0; k < 5; k++) wr(2'd2, 32'h11 + k);
        rd_lit(2'd3, 32'h0000_004A, "status_full_ovf");
        wr(2'd3, 32'd0);
        rd_lit(2'd3, 32'h0000_0042, "status_ovf_clr");
        m_sent.delete();
        wr(2'd0, 32'd1);
        wr(2'd2, 32'h16);
        rd_lit(2'd3, 32'h0000_0043, "status_push_pop_full");
        wait_idle(600);
        chk("sent_count", 32'(m_sent.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < m_sent.size()) chk("sent_order", m_sent[k], exp_order[k]);

        // Back-to-back frames at divisor 2, IRQ rise and drop
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd2);
        wr(2'd2, 32'hA0);
        wr(2'd2, 32'h0F);
        Addr = {26'd0, 2'd3, 2'b00};
        for (int j = 0; j <= 42; j++) begin
            if (j > 0) @(negedge clk);
            tx_s[j] = tx; irq_s[j] = IRQ; busy_s[j] = Dout[0];
        end
        chk("a0_bit4", tx_s[11], 0);
        chk("a0_bit5", tx_s[12], 1);
        chk("a0_bit7", tx_s[17], 1);
        chk("a0_stop", tx_s[19], 1);
        chk("gap_idle_tx", tx_s[20], 1);
        chk("gap_idle_busy", busy_s[20], 0);
        chk("second_start", tx_s[21], 0);
        chk("irq_before_rise", irq_s[41], 0);
        chk("irq_rise", irq_s[42], 1);
        wr(2'd2, 32'h3C);
        chk("irq_hold_after_write", IRQ, 1);
        @(negedge clk);
        chk("irq_drop", IRQ, 0);
        wait_idle(100);

        // Divisor 0 acts as 1 cycle per bit
        wr(2'd1, 32'd0);
        wr(2'd2, 32'hFF);
        Addr = {26'd0, 2'd3, 2'b00};
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            tx_s[j] = tx; busy_s[j] = Dout[0];
        end
        chk("ff_start", tx_s[0], 0);
        chk("ff_bit0", tx_s[1], 1);
        chk("ff_stop", tx_s[9], 1);
        chk("ff_busy_last", busy_s[9], 1);
        chk("ff_busy_drop", busy_s[10], 0);
        wait_idle(50);

        // Mid-frame divisor write, then reset during bit 5 of the next frame
        wr(2'd1, 32'd8);
        wr(2'd2, 32'h81);
        wr(2'd2, 32'h42);
        Addr = {26'd0, 2'd3, 2'b00};
        for (int j = 0; j <= 94; j++) begin
            if (j > 0) @(negedge clk);
            tx_s[j] = tx; busy_s[j] = Dout[0];
            if (j == 34) begin
                $display("wr reg=1 data=0x00000002");
                Addr = {26'd0, 2'd1, 2'b00}; Din = 32'd2; WE = 1'b1;
            end
            if (j == 35) begin WE = 1'b0; Addr = {26'd0, 2'd3, 2'b00}; end
            if (j == 93) reset = 1'b0;
            if (j == 94) reset = 1'b1;
        end
        chk("div8_start_end", tx_s[7], 0);
        chk("div8_bit0_begin", tx_s[8], 1);
        chk("div8_bit0_end", tx_s[15], 1);
        chk("div8_bit1_begin", tx_s[16], 0);
        chk("div8_bit6_end", tx_s[63], 0);
        chk("div8_bit7_begin", tx_s[64], 1);
        chk("div8_stop_end", tx_s[79], 1);
        chk("div8_busy_last", busy_s[79], 1);
        chk("div8_busy_drop", busy_s[80], 0);
        chk("div2_start", tx_s[81], 0);
        chk("div2_bit0", tx_s[84], 0);
        chk("div2_bit1", tx_s[85], 1);
        chk("div2_bit5", tx_s[93], 0);
        chk("reset_abort_tx", tx_s[94], 1);
        rd_lit(2'd3, 32'h0000_0004, "post_reset_status");
        rd_lit(2'd0, 32'h0000_0000, "post_reset_ctrl");
        rd_lit(2'd1, 32'h0000_0010, "post_reset_divisor");
        repeat (3) @(negedge clk);
        chk("final_tx_idle", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
